// File: rtl/mii_rx_framer.sv
// MII receive framer: strips preamble/SFD, assembles nibbles into a byte stream
// with SOP/EOP markers and reports CRC-32, length and dribble status at end of frame.
module mii_rx_framer #(
  parameter int MIN_PRE = 7,
  parameter int MAX_LEN = 1522,
  parameter int MIN_LEN = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  rx_d,
  input  logic        rx_dv,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sop,
  output logic        out_eop,
  output logic        crc_ok,
  output logic        err_len,
  output logic        err_dribble,
  output logic [15:0] frame_cnt
);

  localparam int CW = $clog2(MAX_LEN + 2);
  localparam logic [CW-1:0] MAX_C     = CW'(MAX_LEN);
  localparam logic [CW-1:0] MIN_C     = CW'(MIN_LEN);
  localparam logic [CW-1:0] SAT_C     = CW'(MAX_LEN + 1);
  localparam logic [CW-1:0] ONE_C     = CW'(1);
  localparam logic [3:0]    MIN_PRE_C = 4'(MIN_PRE);
  localparam logic [31:0]   RESIDUE_C = 32'hDEBB20E3;

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  // One nibble through the reflected CRC-32 (poly 0xEDB88320), LSB first.
  function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 4; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  state_t         state_q, state_d;
  logic [3:0]     pre_cnt_q, pre_cnt_d;
  logic           phase_q, phase_d;
  logic [3:0]     low_q, low_d;
  logic [31:0]    crc_q, crc_d;
  logic [CW-1:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]     hold_q, hold_d;
  logic           hold_vld_q, hold_vld_d;
  logic           first_q, first_d;
  logic [7:0]     out_data_q, out_data_d;
  logic           out_valid_q, out_valid_d;
  logic           out_sop_q, out_sop_d;
  logic           out_eop_q, out_eop_d;
  logic           crc_ok_q, crc_ok_d;
  logic           err_len_q, err_len_d;
  logic           err_drib_q, err_drib_d;
  logic [15:0]    frame_cnt_q, frame_cnt_d;

  logic [7:0]     byte_s;
  logic [31:0]    crc_byte_s;
  logic           end_ok_s, end_len_s;

  assign byte_s     = {rx_d, low_q};
  assign crc_byte_s = crc_nib(crc_nib(crc_q, low_q), rx_d);
  assign end_ok_s   = (crc_q == RESIDUE_C);
  assign end_len_s  = (byte_cnt_q < MIN_C) || (byte_cnt_q > MAX_C);

  // Next-state and output decode; the CRC only advances on completed bytes so a
  // trailing dribble nibble never reaches it.
  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    phase_d     = phase_q;
    low_d       = low_q;
    crc_d       = crc_q;
    byte_cnt_d  = byte_cnt_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    first_d     = first_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    out_sop_d   = 1'b0;
    out_eop_d   = 1'b0;
    crc_ok_d    = 1'b0;
    err_len_d   = 1'b0;
    err_drib_d  = 1'b0;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      IDLE: begin
        if (rx_dv) begin
          if (rx_d == 4'h5) begin
            state_d   = PRE;
            pre_cnt_d = 4'd1;
          end else begin
            state_d = DROP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      PRE: begin
        if (!rx_dv) begin
          state_d = IDLE;
        end else if (rx_d == 4'h5) begin
          pre_cnt_d = (pre_cnt_q == 4'hF) ? pre_cnt_q : pre_cnt_q + 4'd1;
        end else if ((rx_d == 4'hD) && (pre_cnt_q >= MIN_PRE_C)) begin
          state_d    = DATA;
          crc_d      = 32'hFFFFFFFF;
          byte_cnt_d = '0;
          phase_d    = 1'b0;
          hold_vld_d = 1'b0;
          first_d    = 1'b1;
        end else begin
          state_d = DROP;
        end
      end
      DATA: begin
        if (rx_dv) begin
          if (!phase_q) begin
            low_d   = rx_d;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            crc_d   = crc_byte_s;
            if (byte_cnt_q != SAT_C) begin
              byte_cnt_d = byte_cnt_q + ONE_C;
            end else begin
              byte_cnt_d = byte_cnt_q;
            end
            // Past MAX_LEN the last in-range byte stays held for the EOP.
            if (byte_cnt_q < MAX_C) begin
              hold_d     = byte_s;
              hold_vld_d = 1'b1;
              if (hold_vld_q) begin
                out_valid_d = 1'b1;
                out_data_d  = hold_q;
                out_sop_d   = first_q;
                first_d     = 1'b0;
              end else begin
                first_d = first_q;
              end
            end else begin
              hold_vld_d = hold_vld_q;
            end
          end
        end else begin
          state_d    = IDLE;
          hold_vld_d = 1'b0;
          if (hold_vld_q) begin
            out_valid_d = 1'b1;
            out_data_d  = hold_q;
            out_sop_d   = first_q;
            out_eop_d   = 1'b1;
            crc_ok_d    = end_ok_s;
            err_len_d   = end_len_s;
            err_drib_d  = phase_q;
            if (end_ok_s && !end_len_s && !phase_q) begin
              frame_cnt_d = frame_cnt_q + 16'd1;
            end else begin
              frame_cnt_d = frame_cnt_q;
            end
          end else begin
            out_valid_d = 1'b0;
          end
        end
      end
      DROP: begin
        if (!rx_dv) state_d = IDLE;
        else        state_d = DROP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pre_cnt_q   <= 4'd0;
      phase_q     <= 1'b0;
      low_q       <= 4'd0;
      crc_q       <= 32'hFFFFFFFF;
      byte_cnt_q  <= '0;
      hold_q      <= 8'd0;
      hold_vld_q  <= 1'b0;
      first_q     <= 1'b0;
      out_data_q  <= 8'd0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      crc_ok_q    <= 1'b0;
      err_len_q   <= 1'b0;
      err_drib_q  <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      phase_q     <= phase_d;
      low_q       <= low_d;
      crc_q       <= crc_d;
      byte_cnt_q  <= byte_cnt_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      first_q     <= first_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      crc_ok_q    <= crc_ok_d;
      err_len_q   <= err_len_d;
      err_drib_q  <= err_drib_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_sop     = out_sop_q;
  assign out_eop     = out_eop_q;
  assign crc_ok      = crc_ok_q;
  assign err_len     = err_len_q;
  assign err_dribble = err_drib_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_mii_rx_framer.sv
// Randomized self-checking bench for mii_rx_framer; expected byte streams and
// status come from a frame-level model (FCS match, length limits, nibble parity).
module tb_mii_rx_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  rx_d = 4'd0;
  logic        rx_dv = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid, out_sop, out_eop, crc_ok, err_len, err_dribble;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  mii_rx_framer dut (
    .clk(clk), .rst(rst), .rx_d(rx_d), .rx_dv(rx_dv),
    .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .crc_ok(crc_ok), .err_len(err_len), .err_dribble(err_dribble), .frame_cnt(frame_cnt)
  );

  int          ncmp = 0;
  int          nfail = 0;
  int          bad_status = 0;
  logic [12:0] cap[$];
  logic [12:0] exp_q[$];
  logic [7:0]  frm[$];
  logic [15:0] exp_cnt = 16'd0;

  // Strobe capture: {sop, eop, crc_ok, err_len, err_dribble, data}.
  always @(negedge clk) begin
    if (out_valid) cap.push_back({out_sop, out_eop, crc_ok, err_len, err_dribble, out_data});
    if (!out_eop && (crc_ok || err_len || err_dribble)) bad_status <= bad_status + 1;
  end

  function automatic logic [31:0] fcs_of(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, frm[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic make_frame(input int n);
    logic [31:0] f;
    frm.delete();
    for (int i = 0; i < n - 4; i++) frm.push_back(8'($urandom_range(255, 0)));
    f = fcs_of(n - 4);
    frm.push_back(f[7:0]);
    frm.push_back(f[15:8]);
    frm.push_back(f[23:16]);
    frm.push_back(f[31:24]);
  endtask

  // Frame-level reference: what the consumer should see for frm (+ optional dribble).
  task automatic model(input bit drib);
    int n, nout;
    bit ok, bad_len;
    logic [31:0] f;
    n = frm.size();
    nout = (n > 1522) ? 1522 : n;
    ok = 1'b0;
    if (n >= 4) begin
      f = fcs_of(n - 4);
      ok = (f == {frm[n-1], frm[n-2], frm[n-3], frm[n-4]});
    end
    bad_len = (n < 64) || (n > 1522);
    for (int i = 0; i < nout; i++) begin
      exp_q.push_back({(i == 0), (i == nout - 1), ok && (i == nout - 1),
                       bad_len && (i == nout - 1), drib && (i == nout - 1), frm[i]});
    end
    if (nout > 0 && ok && !bad_len && !drib) exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic nib(input logic [3:0] n);
    rx_dv = 1'b1;
    rx_d  = n;
    @(negedge clk);
  endtask

  task automatic send(input int npre, input int nbytes, input bit drib, input int gap);
    for (int i = 0; i < npre; i++) nib(4'h5);
    nib(4'hD);
    for (int i = 0; i < nbytes; i++) begin
      nib(frm[i][3:0]);
      nib(frm[i][7:4]);
    end
    if (drib) nib(4'($urandom_range(15, 0)));
    rx_dv = 1'b0;
    rx_d  = 4'd0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    ncmp++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    ncmp++; if (out_sop !== 1'b0) begin nfail++; $display("FAIL reset_sop: got %b expected 0", out_sop); end
    ncmp++; if (out_eop !== 1'b0) begin nfail++; $display("FAIL reset_eop: got %b expected 0", out_eop); end
    ncmp++; if ({crc_ok, err_len, err_dribble} !== 3'b000) begin nfail++; $display("FAIL reset_status: got %b expected 000", {crc_ok, err_len, err_dribble}); end
    ncmp++; if (out_data !== 8'd0) begin nfail++; $display("FAIL reset_data: got %h expected 00", out_data); end
    ncmp++; if (frame_cnt !== 16'd0) begin nfail++; $display("FAIL reset_cnt: got %0d expected 0", frame_cnt); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_good();
    make_frame(64); model(1'b0);
    send($urandom_range(15, 7), frm.size(), 1'b0, 4);
    ncmp++; if (cap.size() !== exp_q.size()) begin nfail++; $display("FAIL good_count: got %0d expected %0d", cap.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < cap.size()) begin ncmp++; if (cap[i] !== exp_q[i]) begin nfail++; $display("FAIL good_byte[%0d]: got %h expected %h", i, cap[i], exp_q[i]); end end
    ncmp++; if (frame_cnt !== exp_cnt) begin nfail++; $display("FAIL good_cnt: got %0d expected %0d", frame_cnt, exp_cnt); end
    cap.delete(); exp_q.delete();
  endtask

  task automatic test_crc_error();
    int k;
    logic [7:0] t;
    make_frame(64);
    k = $urandom_range(7, 0);
    t = frm[10]; t[k] = ~t[k]; frm[10] = t;
    model(1'b0);
    send(7, frm.size(), 1'b0, 4);
    ncmp++; if (cap.size() !== exp_q.size()) begin nfail++; $display("FAIL crc_count: got %0d expected %0d", cap.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < cap.size()) begin ncmp++; if (cap[i] !== exp_q[i]) begin nfail++; $display("FAIL crc_byte[%0d]: got %h expected %h", i, cap[i], exp_q[i]); end end
    ncmp++; if (frame_cnt !== exp_cnt) begin nfail++; $display("FAIL crc_cnt: got %0d expected %0d", frame_cnt, exp_cnt); end
    cap.delete(); exp_q.delete();
  endtask

  task automatic test_short_preamble();
    make_frame(64);
    send(4, frm.size(), 1'b0, 1);
    make_frame(64 + $urandom_range(30, 0)); model(1'b0);
    send(7, frm.size(), 1'b0, 4);
    ncmp++; if (cap.size() !== exp_q.size()) begin nfail++; $display("FAIL shortpre_count: got %0d expected %0d", cap.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < cap.size()) begin ncmp++; if (cap[i] !== exp_q[i]) begin nfail++; $display("FAIL shortpre_byte[%0d]: got %h expected %h", i, cap[i], exp_q[i]); end end
    ncmp++; if (frame_cnt !== exp_cnt) begin nfail++; $display("FAIL shortpre_cnt: got %0d expected %0d", frame_cnt, exp_cnt); end
    cap.delete(); exp_q.delete();
  endtask

  task automatic test_dribble();
    make_frame(64); model(1'b1);
    send(8, frm.size(), 1'b1, 4);
    ncmp++; if (cap.size() !== exp_q.size()) begin nfail++; $display("FAIL dribble_count: got %0d expected %0d", cap.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < cap.size()) begin ncmp++; if (cap[i] !== exp_q[i]) begin nfail++; $display("FAIL dribble_byte[%0d]: got %h expected %h", i, cap[i], exp_q[i]); end end
    ncmp++; if (frame_cnt !== exp_cnt) begin nfail++; $display("FAIL dribble_cnt: got %0d expected %0d", frame_cnt, exp_cnt); end
    cap.delete(); exp_q.delete();
  endtask

  task automatic test_length();
    make_frame(40); model(1'b0);
    send(7, frm.size(), 1'b0, 2);
    make_frame(1600); model(1'b0);
    send(7, frm.size(), 1'b0, 4);
    ncmp++; if (cap.size() !== exp_q.size()) begin nfail++; $display("FAIL len_count: got %0d expected %0d", cap.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < cap.size()) begin ncmp++; if (cap[i] !== exp_q[i]) begin nfail++; $display("FAIL len_byte[%0d]: got %h expected %h", i, cap[i], exp_q[i]); end end
    ncmp++; if (frame_cnt !== exp_cnt) begin nfail++; $display("FAIL len_cnt: got %0d expected %0d", frame_cnt, exp_cnt); end
    cap.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int eops;
    make_frame(80);
    send(7, 20, 1'b0, 0);
    rst = 1'b1; rx_dv = 1'b0; rx_d = 4'd0;
    @(negedge clk);
    ncmp++;
    if ({out_valid, out_sop, out_eop, crc_ok, err_len, err_dribble, out_data, frame_cnt} !== 30'd0) begin
      nfail++; $display("FAIL rstmid_outputs: got %h expected 0",
        {out_valid, out_sop, out_eop, crc_ok, err_len, err_dribble, out_data, frame_cnt});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    eops = 0;
    foreach (cap[i]) if (cap[i][11]) eops++;
    ncmp++; if (eops !== 0) begin nfail++; $display("FAIL rstmid_eop: got %0d eops expected 0", eops); end
    cap.delete(); exp_q.delete();
    exp_cnt = 16'd0;
    make_frame(70); model(1'b0);
    send(9, frm.size(), 1'b0, 4);
    ncmp++; if (cap.size() !== exp_q.size()) begin nfail++; $display("FAIL rstmid_count: got %0d expected %0d", cap.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < cap.size()) begin ncmp++; if (cap[i] !== exp_q[i]) begin nfail++; $display("FAIL rstmid_byte[%0d]: got %h expected %h", i, cap[i], exp_q[i]); end end
    ncmp++; if (frame_cnt !== exp_cnt) begin nfail++; $display("FAIL rstmid_cnt: got %0d expected %0d", frame_cnt, exp_cnt); end
    cap.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    bit drib;
    for (int f = 0; f < 6; f++) begin
      make_frame(($urandom_range(3, 0) == 0) ? $urandom_range(63, 20) : $urandom_range(120, 64));
      drib = ($urandom_range(3, 0) == 0);
      model(drib);
      send($urandom_range(15, 7), frm.size(), drib, 1);
    end
    repeat (4) @(negedge clk);
    ncmp++; if (cap.size() !== exp_q.size()) begin nfail++; $display("FAIL b2b_count: got %0d expected %0d", cap.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < cap.size()) begin ncmp++; if (cap[i] !== exp_q[i]) begin nfail++; $display("FAIL b2b_byte[%0d]: got %h expected %h", i, cap[i], exp_q[i]); end end
    ncmp++; if (frame_cnt !== exp_cnt) begin nfail++; $display("FAIL b2b_cnt: got %0d expected %0d", frame_cnt, exp_cnt); end
    ncmp++; if (bad_status !== 0) begin nfail++; $display("FAIL status_outside_eop: got %0d cycles expected 0", bad_status); end
    cap.delete(); exp_q.delete();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_good();
    test_crc_error();
    test_short_preamble();
    test_dribble();
    test_length();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
